// File: rtl/fir_mac_sequencer.sv
// Purpose: sequencer for the 4-tap FIR MAC. It holds the coefficients and the delay line, runs one MAC transaction per sample and saturates the result.
// Latency: 6 cycles from the input accept edge to out_valid. The minimum sample period is 8 cycles.
// Backpressure: in_ready is high only in IDLE. The result is held in OUT until out_ready is seen.
// Ports: in_* is the sample stream. coef_* is the coefficient write port (writes are dropped while busy).
//        mac_enable, h_*, data_* go to the MAC. mac_data_out and mac_done come back from it.
//        out_* is the result stream. mac_err is a sticky flag for a missing mac_done.
module fir_mac_sequencer #(
    parameter int MAC_CYCLES   = 5,
    parameter int DONE_TIMEOUT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       coef_wr,
    input  logic [1:0] coef_addr,
    input  logic [7:0] coef_data,
    output logic       coef_busy,
    output logic       mac_enable,
    output logic [7:0] h_0,
    output logic [7:0] h_1,
    output logic [7:0] h_2,
    output logic [7:0] h_3,
    output logic [7:0] data_0,
    output logic [7:0] data_1,
    output logic [7:0] data_2,
    output logic [7:0] data_3,
    input  logic [9:0] mac_data_out,
    input  logic       mac_done,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sat,
    output logic       mac_err
);

    typedef enum logic [1:0] {IDLE, RUN, CAPTURE, OUT} state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt;        // enable-window count in RUN, wait count in CAPTURE
    logic [7:0] h_r [4];
    logic [7:0] x_r [4];
    logic       accept;
    logic       run_last;
    logic       cap_timeout;
    logic [7:0] sat_dat;
    logic       sat_flag;

    assign accept      = in_valid && in_ready;
    assign run_last    = (cnt == 4'(MAC_CYCLES - 1));
    assign cap_timeout = (cnt == 4'(DONE_TIMEOUT - 1));

    // The 10-bit value fits in 8 bits only when bits [9:7] are all equal.
    always_comb begin
        sat_dat  = mac_data_out[7:0];
        sat_flag = 1'b0;
        if (!mac_data_out[9] && (mac_data_out[8:7] != 2'b00)) begin
            sat_dat  = 8'h7F;
            sat_flag = 1'b1;
        end else if (mac_data_out[9] && (mac_data_out[8:7] != 2'b11)) begin
            sat_dat  = 8'h80;
            sat_flag = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (run_last) state_nxt = CAPTURE;
            CAPTURE: if (mac_done || cap_timeout) state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Combinational outputs
    always_comb begin
        in_ready  = (state == IDLE);
        coef_busy = (state != IDLE);
    end

    // Registered datapath and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            mac_enable <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_sat    <= 1'b0;
            mac_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                h_r[i] <= '0;
                x_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (coef_wr) h_r[coef_addr] <= coef_data;
                    if (accept) begin
                        x_r[3]     <= x_r[2];
                        x_r[2]     <= x_r[1];
                        x_r[1]     <= x_r[0];
                        x_r[0]     <= in_data;
                        mac_enable <= 1'b1;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    // Enable drops at the last window edge, so the MAC never sees a sixth enable.
                    if (run_last) begin
                        mac_enable <= 1'b0;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                CAPTURE: begin
                    if (mac_done) begin
                        out_data  <= sat_dat;
                        out_sat   <= sat_flag;
                        out_valid <= 1'b1;
                    end else if (cap_timeout) begin
                        mac_err   <= 1'b1;
                        out_data  <= '0;
                        out_sat   <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                OUT: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign h_0    = h_r[0];
    assign h_1    = h_r[1];
    assign h_2    = h_r[2];
    assign h_3    = h_r[3];
    assign data_0 = x_r[0];
    assign data_1 = x_r[1];
    assign data_2 = x_r[2];
    assign data_3 = x_r[3];

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Purpose: self-checking bench for fir_mac_sequencer with a behavioural MAC and an output scoreboard.
// Latency: checks the 6-cycle accept-to-valid latency (8 cycles on a done timeout).
// Backpressure: stalls out_ready and checks that the output is held and input is blocked.
module tb_fir_mac_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       coef_wr = 1'b0;
    logic [1:0] coef_addr = '0;
    logic [7:0] coef_data = '0;
    logic       coef_busy;
    logic       mac_enable;
    logic [7:0] h_0, h_1, h_2, h_3;
    logic [7:0] data_0, data_1, data_2, data_3;
    logic [9:0] mac_data_out = '0;
    logic       mac_done = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_sat;
    logic       mac_err;

    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         exp_lat = 6;
    int         en_cnt = 0;
    bit         mac_kill = 1'b0;
    bit         prev_ov = 1'b0;
    logic [8:0] sb[$];              // {sat, data}
    int         sh[4];              // shadow coefficients
    int         sx[4];              // shadow delay line

    fir_mac_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_busy(coef_busy),
        .mac_enable(mac_enable),
        .h_0(h_0), .h_1(h_1), .h_2(h_2), .h_3(h_3),
        .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .mac_data_out(mac_data_out), .mac_done(mac_done),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_sat(out_sat), .mac_err(mac_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int s8(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // The MAC multiplies Q1.7 by Q1.7 and truncates toward zero back to 7 fractional bits.
    function automatic logic [9:0] mac_calc();
        int acc;
        acc = s8(h_0)*s8(data_0) + s8(h_1)*s8(data_1) + s8(h_2)*s8(data_2) + s8(h_3)*s8(data_3);
        return 10'(acc / 128);
    endfunction

    // Behavioural MAC. It counts the enable window and then returns a done pulse with the result.
    always @(negedge clk) begin
        if (!rst_n) begin
            en_cnt   = 0;
            mac_done = 1'b0;
        end else if (mac_enable) begin
            en_cnt++;
            mac_done = 1'b0;
        end else if (en_cnt != 0) begin
            check("mac_enable_len", en_cnt, 5);
            if (!mac_kill) begin
                mac_data_out = mac_calc();
                mac_done     = 1'b1;
            end
            en_cnt = 0;
        end else begin
            mac_done = 1'b0;
        end
    end

    // Output monitor. It checks latency on the rising edge of out_valid and pops the scoreboard on each transfer.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n) begin
            if (out_valid && !prev_ov) check("latency", cyc - acc_cyc, exp_lat);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e[7:0]);
                    check("out_sat", out_sat, e[8]);
                end
            end
        end
        prev_ov = out_valid;
    end

    function automatic logic [8:0] expect_out();
        int v;
        v = (sh[0]*sx[0] + sh[1]*sx[1] + sh[2]*sx[2] + sh[3]*sx[3]) / 128;
        if (mac_kill) return 9'h000;
        if (v > 127)  return 9'h17F;
        if (v < -128) return 9'h180;
        return {1'b0, 8'(v)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        for (int i = 0; i < 4; i++) begin
            sh[i] = 0;
            sx[i] = 0;
        end
    endtask

    task automatic wr_coef(input int a, input logic [7:0] d);
        @(negedge clk);
        coef_wr   = 1'b1;
        coef_addr = 2'(a);
        coef_data = d;
        sh[a]     = s8(d);
        @(negedge clk);
        coef_wr   = 1'b0;
    endtask

    // Drive one sample once the DUT is ready, and push its expected result.
    task automatic send(input logic [7:0] x);
        int t;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check("in_ready_timeout", int'(in_ready), 1);
        in_data  = x;
        in_valid = 1'b1;
        for (int i = 3; i > 0; i--) sx[i] = sx[i-1];
        sx[0] = s8(x);
        sb.push_back(expect_out());
        @(negedge clk);
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || out_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_coef_busy", int'(coef_busy), 0);
        check("rst_mac_enable", int'(mac_enable), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", out_data, 0);
        check("rst_mac_err", int'(mac_err), 0);
        check("rst_h_0", h_0, 0);
        do_reset();

        // Basic product: 0.5 * 127/128 -> 0x3F
        wr_coef(0, 8'h40);
        wr_coef(1, 8'h00);
        wr_coef(2, 8'h00);
        wr_coef(3, 8'h00);
        check("h_0_load", h_0, 8'h40);
        send(8'h7F);
        check("data_0_shift", data_0, 8'h7F);
        check("busy_in_run", int'(coef_busy), 1);
        drain();

        // Positive saturation
        do_reset();
        for (int i = 0; i < 4; i++) wr_coef(i, 8'h7F);
        for (int i = 0; i < 4; i++) send(8'h7F);
        drain();
        check("data_3_shift", data_3, 8'h7F);

        // Negative saturation
        do_reset();
        for (int i = 0; i < 4; i++) wr_coef(i, 8'h7F);
        for (int i = 0; i < 4; i++) send(8'h81);
        drain();

        // Backpressure: the result is held, input is blocked, and in_valid pulses are ignored.
        out_ready = 1'b0;
        send(8'h10);
        repeat (6) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            in_data  = 8'h55;
            in_valid = i[0];
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_data", out_data, sb[0][7:0]);
            check("bp_in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("bp_data_0", data_0, 8'h10);
        out_ready = 1'b1;
        drain();
        send(8'h20);
        check("bp_next_accept", data_0, 8'h20);
        drain();

        // Coefficient write while busy is dropped, then it takes effect in IDLE.
        do_reset();
        wr_coef(0, 8'h40);
        send(8'h7F);
        @(negedge clk);
        coef_wr = 1'b1; coef_addr = 2'd0; coef_data = 8'h7F;
        @(negedge clk);
        coef_wr = 1'b0;
        check("busy_wr_dropped", h_0, 8'h40);
        drain();
        wr_coef(0, 8'h7F);
        check("idle_wr_taken", h_0, 8'h7F);

        // Missing done leads to a timeout error with a zero result.
        mac_kill = 1'b1;
        exp_lat  = 8;
        send(8'h33);
        drain();
        check("timeout_mac_err", int'(mac_err), 1);
        mac_kill = 1'b0;
        exp_lat  = 6;

        // Reset in the middle of RUN
        send(8'h44);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mac_enable", int'(mac_enable), 0);
        check("arst_mac_err", int'(mac_err), 0);
        check("arst_h_0", h_0, 0);
        check("arst_data_0", data_0, 0);
        check("arst_out_valid", int'(out_valid), 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", int'(in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fir_mac_sequencer.md
Name: fir_mac_sequencer

Overview:
Control and datapath front-end that drives the 4-tap MAC unit in the FIR filter. It owns the coefficient registers and the 4-sample delay line, and accepts input samples on a valid/ready stream. For each accepted sample it runs one MAC transaction (enable window, then wait for done), saturates the 10-bit MAC result to 8-bit Q1.7, and presents it on a valid/ready output stream.

Parameters:
MAC_CYCLES, 5, number of consecutive clock edges mac_enable is held high per transaction; fixed by the MAC protocol.
DONE_TIMEOUT, 3, max cycles spent in CAPTURE waiting for mac_done before declaring an error.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  input sample, Q1.7 two's complement
in_valid  input  1  in_data valid
in_ready  output  1  sequencer can accept a sample
coef_wr  input  1  coefficient write strobe
coef_addr  input  2  coefficient index 0..3
coef_data  input  8  coefficient value, Q1.7 two's complement
coef_busy  output  1  high when state != IDLE; coef writes are dropped
mac_enable  output  1  MAC enable, registered
h_0..h_3  output  8 each  coefficient registers to MAC
data_0..data_3  output  8 each  delay line to MAC; data_0 = newest x[n], data_3 = x[n-3]
mac_data_out  input  10  MAC accumulation result, two's complement, 7 fractional bits
mac_done  input  1  MAC result-valid pulse
out_data  output  8  saturated filter output, Q1.7
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_sat  output  1  out_data was clipped; valid with out_valid
mac_err  output  1  sticky error: mac_done missing; cleared only by reset

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk. On reset, all registers clear to 0: state=IDLE, mac_enable, h_*, data_*, out_data, out_valid, out_sat, mac_err. Reset mid-transaction aborts immediately and drops mac_enable asynchronously.
- FSM states: IDLE, RUN, CAPTURE, OUT. in_ready = (state==IDLE), combinational. coef_busy = !in_ready.
- IDLE:
  - coef_wr loads h_[coef_addr] <= coef_data.
  - On in_valid&&in_ready at edge A:
    - Shift the delay line: data_3<=data_2, data_2<=data_1, data_1<=data_0, data_0<=in_data.
    - mac_enable<=1, run_cnt<=0, go to RUN.
  - If coef_wr and an accept happen at the same edge, both take effect.
- RUN:
  - mac_enable is high for exactly MAC_CYCLES edges (A+1..A+5). run_cnt increments each edge.
  - When run_cnt==MAC_CYCLES-1, mac_enable<=0 and go to CAPTURE at edge A+5.
  - mac_enable must not be high at edge A+6, otherwise the MAC restarts.
- CAPTURE:
  - At the first edge with mac_done==1 (nominally A+6), latch sat(mac_data_out) into out_data, set out_sat accordingly, set out_valid<=1, go to OUT.
  - If DONE_TIMEOUT edges pass without mac_done: mac_err<=1, out_data<=0, out_sat<=0, out_valid<=1, go to OUT.
- OUT:
  - Hold out_valid, out_data and out_sat stable until out_ready is high at an edge. At that edge out_valid<=0 and go to IDLE.
  - in_valid is ignored while in OUT.
- h_* and data_* change only in IDLE, so they are stable for the whole MAC transaction.
- Saturation (10-bit signed v to 8-bit): v>127 gives 0x7F and out_sat=1; v<-128 gives 0x80 and out_sat=1; otherwise v[7:0] and out_sat=0.
- Timing: latency from accept edge to out_valid is 6 cycles. Minimum sample period is 8 cycles, with out_ready held high.
- coef_wr while busy is silently dropped.

Test Plan:
- Basic product: h_0=0x40, h_1..h_3=0, in_data=0x7F -> out_data=0x3F, out_sat=0, out_valid at accept+6, mac_enable high for exactly 5 cycles.
- Positive saturation: all h=0x7F, four samples of 0x7F -> outputs 0x7E, 0x7F (sat=1), 0x7F (sat=1), 0x7F (sat=1).
- Negative saturation: all h=0x7F, four samples of 0x81 -> outputs 0x82 (sat=0), then 0x80 (sat=1) three times.
- Backpressure: out_ready=0 for 10 cycles -> out_valid/out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, next sample accepted.
- Busy coefficient write: coef_wr addr=0 data=0x7F during RUN -> h_0 unchanged; the same write in IDLE -> h_0=0x7F.
- Missing done / reset: mac_done tied 0 -> mac_err=1 and out_data=0 after 3 CAPTURE cycles; rst_n low mid-RUN -> mac_enable=0 immediately, all outputs 0, in_ready=1 after release.
